ctls_nway: RTL and testbench

CTLS_NWAY -- requirements
Module: ctls_nway

---
 rtl/ctls_nway.sv | 180 ++++++++++++++++++
 tb/tb_ctls_nway.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctls_nway.sv
`default_nettype none
// ============================================================================
// Module   : ctls_nway
// Brief    : N-way traffic-light controller cycling ALLRED -> GREEN -> YELLOW
//            with demand-driven round-robin phase selection. The blinking
//            flash mode is compiled in only when CTLS_FLASH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ctls_nway #(
    parameter int NUM_DIR    = 4,
    parameter int CW         = 8,
    parameter int FLASH_HALF = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef CTLS_FLASH_EN
    input  logic                       flash,
`endif
    input  logic [NUM_DIR*CW-1:0]      green_time,
    input  logic [CW-1:0]              yellow_time,
    input  logic [CW-1:0]              allred_time,
    input  logic [NUM_DIR-1:0]         demand,
    output logic [3*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] phase,
    output logic [1:0]                 state
);

    localparam int PW = $clog2(NUM_DIR);

    localparam logic [1:0]    c_allred   = 2'b00;
    localparam logic [1:0]    c_green    = 2'b01;
    localparam logic [1:0]    c_yellow   = 2'b10;
    localparam logic [1:0]    c_flash    = 2'b11;
    localparam logic [2:0]    c_lamp_g   = 3'b100;
    localparam logic [2:0]    c_lamp_y   = 3'b010;
    localparam logic [2:0]    c_lamp_r   = 3'b001;
    localparam logic [PW-1:0] c_last_dir = PW'(NUM_DIR - 1);

`ifdef CTLS_FLASH_EN
    localparam int            FW          = $clog2(2 * FLASH_HALF);
    localparam logic [2:0]    c_lamp_off  = 3'b000;
    localparam logic [FW-1:0] c_blink_max = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] c_blink_on  = FW'(FLASH_HALF);
`endif

    if (NUM_DIR < 2 || NUM_DIR > 8 || CW < 1 || FLASH_HALF < 1) begin : g_param_check
        $error("ctls_nway: parameter out of range");
    end

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic [PW-1:0] w_search;
    logic          w_last;
`ifdef CTLS_FLASH_EN
    logic [FW-1:0] r_blink;
    logic [FW-1:0] w_blink_nxt;
`endif

    // A zero duration still occupies one cycle.
    function automatic logic [CW-1:0] min1(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    // Round-robin search starting one past the current phase; the final
    // offset (NUM_DIR) lands back on the current phase itself.
    always_comb begin : p_search
        logic [PW:0] w_sum;
        logic        w_found;
        w_search = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int i = 1; i <= NUM_DIR; i++) begin
            w_sum = {1'b0, r_phase} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NUM_DIR)) begin
                w_sum = w_sum - (PW+1)'(NUM_DIR);
            end
            if (i == 1) begin
                w_search = w_sum[PW-1:0];
            end
            if (!w_found && demand[w_sum[PW-1:0]]) begin
                w_search = w_sum[PW-1:0];
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : p_state_reg
        if (!rst) begin
            r_state <= c_allred;
            r_phase <= c_last_dir;
            r_cnt   <= min1(allred_time);
`ifdef CTLS_FLASH_EN
            r_blink <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef CTLS_FLASH_EN
            r_blink <= w_blink_nxt;
`endif
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt - CW'(1);
        w_last      = (r_cnt <= CW'(1));
        case (r_state)
            c_allred: begin
                if (w_last) begin
                    w_state_nxt = c_green;
                    w_phase_nxt = w_search;
                    w_cnt_nxt   = min1(green_time[int'(w_search)*CW +: CW]);
                end
            end
            c_green: begin
                if (w_last) begin
                    w_state_nxt = c_yellow;
                    w_cnt_nxt   = min1(yellow_time);
                end
            end
            c_yellow: begin
                if (w_last) begin
                    w_state_nxt = c_allred;
                    w_cnt_nxt   = min1(allred_time);
                end
            end
            c_flash: begin
                // Leaving flash always restarts a full clearance interval.
                w_state_nxt = c_allred;
                w_cnt_nxt   = min1(allred_time);
            end
        endcase
`ifdef CTLS_FLASH_EN
        w_blink_nxt = (r_blink == c_blink_max) ? '0 : r_blink + FW'(1);
        if (flash) begin
            w_state_nxt = c_flash;
            w_phase_nxt = r_phase;
            w_cnt_nxt   = r_cnt;
            if (r_state != c_flash) begin
                w_blink_nxt = '0;
            end
        end
`endif
    end

    always_comb begin : p_outputs
        for (int k = 0; k < NUM_DIR; k++) begin
            lights[3*k +: 3] = c_lamp_r;
        end
        case (r_state)
            c_allred: begin
            end
            c_green: begin
                lights[3*int'(r_phase) +: 3] = c_lamp_g;
            end
            c_yellow: begin
                lights[3*int'(r_phase) +: 3] = c_lamp_y;
            end
            c_flash: begin
`ifdef CTLS_FLASH_EN
                for (int k = 0; k < NUM_DIR; k++) begin
                    lights[3*k +: 3] = (r_blink < c_blink_on) ? c_lamp_y : c_lamp_off;
                end
`endif
            end
        endcase
    end

    assign phase = r_phase;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctls_nway.sv
`default_nettype none
// tb_ctls_nway: table-driven scoreboard bench for ctls_nway (NUM_DIR=4, CW=8).
// Flash-mode rows are added only when CTLS_FLASH_EN is defined.
`timescale 1ns/1ps
module tb_ctls_nway;

    localparam int ND = 4;
    localparam int CW = 8;

    localparam logic [1:0] AR = 2'b00;
    localparam logic [1:0] G  = 2'b01;
    localparam logic [1:0] Y  = 2'b10;
    localparam logic [1:0] FL = 2'b11;

    localparam logic [31:0] GTA = 32'h04030201; // dir k green = k+1 cycles
    localparam logic [31:0] GTB = 32'h04010201; // dir 2 shortened to 1

    logic              clk = 1'b0;
    logic              rst = 1'b0;
`ifdef CTLS_FLASH_EN
    logic              flash = 1'b0;
`endif
    logic [ND*CW-1:0]  green_time = '0;
    logic [CW-1:0]     yellow_time = '0;
    logic [CW-1:0]     allred_time = '0;
    logic [ND-1:0]     demand = '0;
    logic [3*ND-1:0]   lights;
    logic [1:0]        phase;
    logic [1:0]        state;

    ctls_nway #(.NUM_DIR(ND), .CW(CW), .FLASH_HALF(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CTLS_FLASH_EN
        .flash       (flash),
`endif
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .allred_time (allred_time),
        .demand      (demand),
        .lights      (lights),
        .phase       (phase),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] gt;
        logic [7:0]  yt;
        logic [7:0]  at;
        logic [3:0]  dm;
        logic        fl;
        logic [1:0]  st;
        logic [1:0]  ph;
        logic        off;
        int          len;
    } row_t;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  ph;
        logic [11:0] lt;
        string       nm;
    } exp_t;

    row_t tbl[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic void add_row(input logic [31:0] gt, input logic [7:0] yt,
                                    input logic [7:0] at, input logic [3:0] dm,
                                    input logic fl, input logic [1:0] st,
                                    input logic [1:0] ph, input logic off, input int len);
        row_t r;
        r.gt = gt; r.yt = yt; r.at = at; r.dm = dm; r.fl = fl;
        r.st = st; r.ph = ph; r.off = off; r.len = len;
        tbl.push_back(r);
    endfunction

    function automatic logic [11:0] lamps(input logic [1:0] st, input logic [1:0] ph,
                                          input logic off);
        logic [11:0] v;
        for (int k = 0; k < ND; k++) v[3*k +: 3] = 3'b001;
        case (st)
            G:  v[3*int'(ph) +: 3] = 3'b100;
            Y:  v[3*int'(ph) +: 3] = 3'b010;
            FL: for (int k = 0; k < ND; k++) v[3*k +: 3] = off ? 3'b000 : 3'b010;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_exp(input logic [1:0] st, input logic [1:0] ph,
                            input logic off, input string nm);
        exp_t e;
        e.st = st; e.ph = ph; e.lt = lamps(st, ph, off); e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: DUT output with no expectation queued");
            return;
        end
        e = sbq.pop_front();
        if (state !== e.st || phase !== e.ph || lights !== e.lt) begin
            errors++;
            $display("FAIL %s: got state=%b phase=%0d lights=%h, want state=%b phase=%0d lights=%h",
                     e.nm, state, phase, lights, e.st, e.ph, e.lt);
        end
    endtask

    task automatic run_rows(input int first, input int last, input string nm);
        for (int r = first; r <= last; r++) begin
            green_time  = tbl[r].gt;
            yellow_time = tbl[r].yt;
            allred_time = tbl[r].at;
            demand      = tbl[r].dm;
`ifdef CTLS_FLASH_EN
            flash       = tbl[r].fl;
`endif
            for (int c = 0; c < tbl[r].len; c++)
                push_exp(tbl[r].st, tbl[r].ph, tbl[r].off, $sformatf("%s_row%0d_cyc%0d", nm, r, c));
            for (int c = 0; c < tbl[r].len; c++) begin
                @(posedge clk);
                #1;
                check_out();
            end
        end
    endtask

    task automatic do_reset(input logic [31:0] gt, input logic [7:0] yt,
                            input logic [7:0] at, input logic [3:0] dm, input string nm);
        green_time = gt; yellow_time = yt; allred_time = at; demand = dm;
`ifdef CTLS_FLASH_EN
        flash = 1'b0;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        push_exp(AR, 2'd3, 1'b0, {nm, "_reset"});
        check_out();
        mon_en = 1'b1;
        rst = 1'b1;
    endtask

    // At most one lamp may be non-red whenever the controller is not flashing.
    always @(negedge clk) begin
        if (mon_en && state !== FL) begin
            int n;
            n = 0;
            for (int k = 0; k < ND; k++) if (lights[3*k +: 3] !== 3'b001) n++;
            checks++;
            if (n > 1) begin
                errors++;
                $display("FAIL single_non_red: got %0d non-red fields (lights=%h), want at most 1", n, lights);
            end
        end
    end

    initial begin
        int a0, a1, b0, b1, c0, c1, d0, d1, e0, e1;
`ifdef CTLS_FLASH_EN
        int f0, f1;
`endif
        // Full round robin with distinct green lengths.
        a0 = tbl.size();
        add_row(GTA, 2, 1, 4'hF, 0, G, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, Y, 0, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, G, 1, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, Y, 1, 0, 2); add_row(GTA, 2, 1, 4'hF, 0, AR, 1, 0, 1);
        add_row(GTA, 2, 1, 4'hF, 0, G, 2, 0, 3); add_row(GTA, 2, 1, 4'hF, 0, Y, 2, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 2, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, G, 3, 0, 4);
        add_row(GTA, 2, 1, 4'hF, 0, Y, 3, 0, 2); add_row(GTA, 2, 1, 4'hF, 0, AR, 3, 0, 1);
        add_row(GTA, 2, 1, 4'hF, 0, G, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, Y, 0, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 0, 0, 1);
        a1 = tbl.size() - 1;
        // Single demanding direction; green_time changed mid-green applies next time.
        b0 = tbl.size();
        add_row(GTA, 2, 2, 4'b0100, 0, AR, 3, 0, 1); add_row(GTA, 2, 2, 4'b0100, 0, G, 2, 0, 1);
        add_row(GTB, 2, 2, 4'b0100, 0, G, 2, 0, 2);  add_row(GTB, 2, 2, 4'b0100, 0, Y, 2, 0, 2);
        add_row(GTB, 2, 2, 4'b0100, 0, AR, 2, 0, 2); add_row(GTB, 2, 2, 4'b0100, 0, G, 2, 0, 1);
        add_row(GTB, 2, 2, 4'b0100, 0, Y, 2, 0, 2);  add_row(GTB, 2, 2, 4'b0100, 0, AR, 2, 0, 2);
        add_row(GTB, 2, 2, 4'b0100, 0, G, 2, 0, 1);
        b1 = tbl.size() - 1;
        // All-zero durations and no demand.
        c0 = tbl.size();
        add_row(0, 0, 0, 4'h0, 0, G, 0, 0, 1); add_row(0, 0, 0, 4'h0, 0, Y, 0, 0, 1);
        add_row(0, 0, 0, 4'h0, 0, AR, 0, 0, 1); add_row(0, 0, 0, 4'h0, 0, G, 1, 0, 1);
        add_row(0, 0, 0, 4'h0, 0, Y, 1, 0, 1); add_row(0, 0, 0, 4'h0, 0, AR, 1, 0, 1);
        add_row(0, 0, 0, 4'h0, 0, G, 2, 0, 1);
        c1 = tbl.size() - 1;
        // Lead-in to a reset asserted in cycle 2 of dir-1 green, then recovery.
        d0 = tbl.size();
        add_row(GTA, 2, 1, 4'hF, 0, G, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, Y, 0, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, G, 1, 0, 2);
        d1 = tbl.size() - 1;
        e0 = tbl.size();
        add_row(GTA, 2, 1, 4'b0110, 0, G, 1, 0, 2); add_row(GTA, 2, 1, 4'b0110, 0, Y, 1, 0, 2);
        add_row(GTA, 2, 1, 4'b0110, 0, AR, 1, 0, 1); add_row(GTA, 2, 1, 4'b0110, 0, G, 2, 0, 3);
        e1 = tbl.size() - 1;
`ifdef CTLS_FLASH_EN
        // Flash held for 20 cycles during dir-2 green.
        f0 = tbl.size();
        add_row(GTA, 2, 1, 4'hF, 0, G, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, Y, 0, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 0, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, G, 1, 0, 2);
        add_row(GTA, 2, 1, 4'hF, 0, Y, 1, 0, 2); add_row(GTA, 2, 1, 4'hF, 0, AR, 1, 0, 1);
        add_row(GTA, 2, 1, 4'hF, 0, G, 2, 0, 1);
        add_row(GTA, 2, 1, 4'hF, 1, FL, 2, 0, 4); add_row(GTA, 2, 1, 4'hF, 1, FL, 2, 1, 4);
        add_row(GTA, 2, 1, 4'hF, 1, FL, 2, 0, 4); add_row(GTA, 2, 1, 4'hF, 1, FL, 2, 1, 4);
        add_row(GTA, 2, 1, 4'hF, 1, FL, 2, 0, 4);
        add_row(GTA, 2, 1, 4'hF, 0, AR, 2, 0, 1); add_row(GTA, 2, 1, 4'hF, 0, G, 3, 0, 4);
        add_row(GTA, 2, 1, 4'hF, 0, Y, 3, 0, 2);
        f1 = tbl.size() - 1;
`endif

        do_reset(GTA, 2, 1, 4'hF, "rr");
        run_rows(a0, a1, "rr");

        do_reset(GTA, 2, 2, 4'b0100, "single");
        run_rows(b0, b1, "single");

        do_reset(0, 0, 0, 4'h0, "zero");
        run_rows(c0, c1, "zero");

        do_reset(GTA, 2, 1, 4'hF, "midrst");
        run_rows(d0, d1, "midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(AR, 2'd3, 1'b0, "midrst_allred_now");
        check_out();
        rst = 1'b1;
        run_rows(e0, e1, "midrst_after");

`ifdef CTLS_FLASH_EN
        do_reset(GTA, 2, 1, 4'hF, "flash");
        run_rows(f0, f1, "flash");
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
